// File: rtl/radix2_signed_divider.sv
// rtl/radix2_signed_divider.sv - sequential radix-2 non-restoring signed divider
//
// Divides a 2*WIDTH-bit signed dividend by a WIDTH-bit signed divisor and
// produces a truncated quotient plus a remainder that takes the dividend's sign.
// It works on magnitudes, resolves one quotient bit per enabled cycle and
// applies the signs in a final fix-up cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en           global enable; 0 freezes every register
//   start        launch request, honoured in IDLE/DONE
//   dividend     2*WIDTH-bit two's complement dividend
//   divisor      WIDTH-bit two's complement divisor
//   ready        result valid (DONE state)
//   quotient     WIDTH-bit signed quotient, truncated toward zero
//   remainder    WIDTH-bit signed remainder, sign of the dividend
//   div_by_zero  divisor was zero
//   overflow     true quotient does not fit in WIDTH signed bits
module radix2_signed_divider #(
  parameter int WIDTH       = 8,
  parameter bit CHECK_PARAM = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  if (CHECK_PARAM && (WIDTH < 2)) begin : g_param_check
    $fatal(1, "radix2_signed_divider: WIDTH must be at least 2");
  end

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     prem;      // partial remainder, two's complement
  logic [WIDTH-1:0]   shreg;     // low dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dmag;      // |divisor|
  logic               sign_q;
  logic               sign_r;
  logic               ovf_pend;
  logic               dz_pend;

  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dsr_mag;
  logic [WIDTH:0]     prem_sh;
  logic [WIDTH:0]     prem_nx;
  logic [WIDTH:0]     rfix;
  logic [WIDTH-1:0]   qmag;
  logic [WIDTH-1:0]   rmag;
  logic               q_ovf;

  always_comb begin
    // Negating the most negative value yields the right unsigned magnitude.
    dvd_mag = dividend[2*WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dsr_mag = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;

    // The partial remainder stays within [-|d|, |d|), so its low WIDTH bits
    // already carry the sign and the shift cannot lose information.
    prem_sh = {prem[WIDTH-1:0], shreg[WIDTH-1]};
    prem_nx = prem[WIDTH] ? (prem_sh + {1'b0, dmag}) : (prem_sh - {1'b0, dmag});

    rfix = prem[WIDTH] ? (prem + {1'b0, dmag}) : prem;
    rmag = rfix[WIDTH-1:0];
    qmag = shreg;

    // A negative result may reach -2^(WIDTH-1); a positive one only 2^(WIDTH-1)-1.
    q_ovf = ovf_pend |
            (sign_q ? (qmag[WIDTH-1] & (|qmag[WIDTH-2:0])) : qmag[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      prem        <= '0;
      shreg       <= '0;
      dmag        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_pend    <= 1'b0;
      dz_pend     <= 1'b0;
      ready       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dmag        <= dsr_mag;
            prem        <= {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
            shreg       <= dvd_mag[WIDTH-1:0];
            sign_q      <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            sign_r      <= dividend[2*WIDTH-1];
            // Upper half >= divisor means the unsigned quotient needs WIDTH+1 bits.
            ovf_pend    <= (dvd_mag[2*WIDTH-1:WIDTH] >= dsr_mag);
            cnt         <= CW'(WIDTH);
            // A zero divisor skips the iteration; the fix cycle publishes the
            // flag so ready rises one cycle after the start edge.
            if (divisor == '0) begin
              dz_pend <= 1'b1;
              state   <= S_FIX;
            end else begin
              dz_pend <= 1'b0;
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt != '0) begin
            prem  <= prem_nx;
            shreg <= {shreg[WIDTH-2:0], ~prem_nx[WIDTH]};
            cnt   <= cnt - CW'(1);
          end else begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          ready <= 1'b1;
          state <= S_DONE;
          if (dz_pend) begin
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
          end else begin
            overflow  <= q_ovf;
            quotient  <= sign_q ? (~qmag + 1'b1) : qmag;
            remainder <= sign_r ? (~rmag + 1'b1) : rmag;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
